uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: baud-timed UART transmitter. One word per accepted request is
// sent as start bit, DATA_BITS data bits (LSB first), optional parity bit and
// STOP_BITS stop bits, each held CLKS_PER_BIT clocks.
//
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY_ODD port and a
// parity bit between the last data bit and the first stop bit.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   TX_EN      enable; gates acceptance of new frames only
//   START      frame request, sampled while idle
//   TX_IN      word to send, captured on acceptance
//   PARITY_ODD parity sense, 1 = odd (only with UART_TX_PARITY_EN)
//   TX_OUT     serial line, idles high
//   BUSY       high from the acceptance edge until the frame ends
//   DONE       one-cycle pulse at the edge the last stop bit completes
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 TX_EN,
  input  logic                 START,
  input  logic [DATA_BITS-1:0] TX_IN,
`ifdef UART_TX_PARITY_EN
  input  logic                 PARITY_ODD,
`endif
  output logic                 TX_OUT,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        baud, baud_nxt;
  logic [BW-1:0]        bitc, bitc_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_nxt;
`endif

  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud + BAUD_ONE;
    bitc_nxt  = bitc;
    shreg_nxt = shreg;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state)
      IDLE: begin
        baud_nxt = '0;
        bitc_nxt = '0;
        busy_nxt = 1'b0;
        if (START && TX_EN) begin
          shreg_nxt = TX_IN;
`ifdef UART_TX_PARITY_EN
          // parity is fixed at capture so later TX_IN/PARITY_ODD changes are harmless
          par_nxt   = (^TX_IN) ^ PARITY_ODD;
`endif
          busy_nxt  = 1'b1;
          state_nxt = START_BIT;
        end
      end
      START_BIT: if (bit_end) state_nxt = DATA;
      DATA: if (bit_end) begin
        shreg_nxt = shreg >> 1;
        if (bitc == DATA_LAST) begin
          bitc_nxt  = '0;
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end else begin
          bitc_nxt = bitc + BIT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: if (bit_end) begin
        if (bitc == STOP_LAST) begin
          bitc_nxt  = '0;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          bitc_nxt = bitc + BIT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bitc_nxt  = '0;
        busy_nxt  = 1'b0;
      end
    endcase

    // TX_OUT is registered from the next state so the line changes on the
    // same edge as the state, with no input-to-output combinational path.
    case (state_nxt)
      START_BIT: tx_nxt = 1'b0;
      DATA:      tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:    tx_nxt = par_nxt;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      baud   <= '0;
      bitc   <= '0;
      shreg  <= '0;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      baud   <= baud_nxt;
      bitc   <= bitc_nxt;
      shreg  <= shreg_nxt;
      TX_OUT <= tx_nxt;
      BUSY   <= busy_nxt;
      DONE   <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par_q  <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame. Two instances: A (4 clk/bit, 8 data,
// 1 stop) and B (4 clk/bit, 5 data, 2 stop), sharing clock and reset.
// Stimulus pushes expected frames (LSB = start bit) per instance; one monitor
// per instance detects each frame start on TX_OUT and checks every cycle.
module tb_uart_tx_frame;
  localparam int C = 4;

`ifdef UART_TX_PARITY_EN
  localparam int NA = 11, NB = 9;
  localparam logic [15:0] F_A5_E = 16'h054A, F_A5_O = 16'h074A;
  localparam logic [15:0] F_3C = 16'h0478, F_0F = 16'h041E, F_5A = 16'h04B4;
  localparam logic [15:0] F_13 = 16'h01E6;
`else
  localparam int NA = 10, NB = 8;
  localparam logic [15:0] F_A5_E = 16'h034A, F_A5_O = 16'h034A;
  localparam logic [15:0] F_3C = 16'h0278, F_0F = 16'h021E, F_5A = 16'h02B4;
  localparam logic [15:0] F_13 = 16'h00E6;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] tx_en, start, par_odd, tx, busy, done;
  logic [7:0] din_a;
  logic [4:0] din_b;
  int tests = 0, fails = 0;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          abort;
  } frame_t;
  frame_t sq[2][$];

  always #5 CLK = ~CLK;

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .TX_EN(tx_en[0]), .START(start[0]), .TX_IN(din_a),
`ifdef UART_TX_PARITY_EN
    .PARITY_ODD(par_odd[0]),
`endif
    .TX_OUT(tx[0]), .BUSY(busy[0]), .DONE(done[0]));

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .TX_EN(tx_en[1]), .START(start[1]), .TX_IN(din_b),
`ifdef UART_TX_PARITY_EN
    .PARITY_ODD(par_odd[1]),
`endif
    .TX_OUT(tx[1]), .BUSY(busy[1]), .DONE(done[1]));

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got {tx,busy,done}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [15:0] b, input int n, input bit ab);
    frame_t f;
    f.bits = b; f.n = n; f.abort = ab;
    sq[id].push_back(f);
  endtask

  task automatic mon(input int id);
    frame_t f;
    int bad;
    bit aborted;
    forever begin
      @(negedge CLK);
      if (!RST_N) continue;
      if (tx[id] === 1'b0) begin
        if (sq[id].size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame dut%0d: frame started, none expected", id);
          while (busy[id] === 1'b1 && RST_N) @(negedge CLK);
          continue;
        end
        f = sq[id].pop_front();
        bad = 0; aborted = 0;
        for (int k = 0; k < f.n * C; k++) begin
          if (k > 0) @(negedge CLK);
          if (!RST_N) begin aborted = 1; break; end
          if (tx[id] !== f.bits[k/C] || busy[id] !== 1'b1 || done[id] !== 1'b0) begin
            if (bad == 0)
              $display("FAIL frame_bits dut%0d cycle %0d: got tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                       id, k, tx[id], busy[id], done[id], f.bits[k/C]);
            bad++;
          end
        end
        tests++;
        if (bad != 0) fails++;
        if (aborted) begin
          chk($sformatf("abort_dut%0d", id), {tx[id], busy[id], done[id]}, 3'b100);
          tests++;
          if (!f.abort) begin fails++; $display("FAIL abort_dut%0d: frame abandoned, expected complete", id); end
        end else begin
          @(negedge CLK);
          chk($sformatf("frame_end_dut%0d", id), {tx[id], busy[id], done[id]}, 3'b101);
          tests++;
          if (f.abort) begin fails++; $display("FAIL abort_dut%0d: frame completed, expected abandon", id); end
        end
      end else if (busy[id] !== 1'b0 || done[id] !== 1'b0) begin
        tests++; fails++;
        $display("FAIL idle_dut%0d: got busy=%b done=%b expected 0 0", id, busy[id], done[id]);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic send_a(input logic [7:0] d);
    @(negedge CLK);
    din_a = d; start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (busy[id] === 1'b0) return;
    end
    tests++; fails++;
    $display("FAIL timeout_dut%0d: busy=%b, expected 0 within 400 cycles", id, busy[id]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; tx_en = 2'b00; start = 2'b00; par_odd = 2'b00;
    din_a = '0; din_b = '0;
    repeat (3) @(negedge CLK);
    chk("reset_a", {tx[0], busy[0], done[0]}, 3'b100);
    chk("reset_b", {tx[1], busy[1], done[1]}, 3'b100);
    RST_N = 1'b1;
    tx_en = 2'b11;

    // A5, then TX_IN trashed and a START pulse mid-frame: both must be ignored
    expect_frame(0, F_A5_E, NA, 0);
    send_a(8'hA5);
    din_a = 8'h00;
    repeat (15) @(negedge CLK);
    start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    wait_idle(0);

    // odd parity sense
    par_odd[0] = 1'b1;
    expect_frame(0, F_A5_O, NA, 0);
    send_a(8'hA5);
    wait_idle(0);
    par_odd[0] = 1'b0;

    // back-to-back on B with START held: accepts at E, E+33, E+66
    din_b = 5'h13;
    for (int i = 0; i < 3; i++) expect_frame(1, F_13, NB, 0);
    @(negedge CLK);
    start[1] = 1'b1;
    repeat (99) @(posedge CLK);
    @(negedge CLK);
    start[1] = 1'b0;
    wait_idle(1);

    // disabled: no frames accepted
    tx_en = 2'b00; start = 2'b11;
    repeat (20) @(negedge CLK);
    chk("disabled_a", {tx[0], busy[0], done[0]}, 3'b100);
    chk("disabled_b", {tx[1], busy[1], done[1]}, 3'b100);
    start = 2'b00; tx_en = 2'b11;

    // TX_EN dropped at bit 3 with START still high: frame completes, no more
    expect_frame(0, F_3C, NA, 0);
    @(negedge CLK);
    din_a = 8'h3C; start[0] = 1'b1;
    repeat (14) @(negedge CLK);
    tx_en[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge CLK);
    chk("en_drop_idle", {tx[0], busy[0], done[0]}, 3'b100);
    start[0] = 1'b0; tx_en[0] = 1'b1;

    // reset during data bit 4 (cycles 20..23 after acceptance)
    expect_frame(0, F_0F, NA, 1);
    send_a(8'h0F);
    repeat (21) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("async_reset", {tx[0], busy[0], done[0]}, 3'b100);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    expect_frame(0, F_5A, NA, 0);
    send_a(8'h5A);
    wait_idle(0);

    repeat (5) @(negedge CLK);
    for (int id = 0; id < 2; id++) begin
      tests++;
      if (sq[id].size() != 0) begin
        fails++;
        $display("FAIL missing_frames dut%0d: %0d left, expected 0", id, sq[id].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
